// File: rtl/seg_pkg.sv
// Shared 7-segment constants and hex decode helper for the scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Indexed by nibble value; entry 15 is the leftmost term.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    return SEG_TABLE[h];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-high segments; blank forces all segments off.
// Purely combinational, no backpressure.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : hex2seg(nib);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with tear-free frame update.
// Outputs registered, 1 cycle behind the digit index; no backpressure (load always accepted).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   data,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic [N_DIGITS-1:0]     blink_mask,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [N_DIGITS-1:0]     an_out,
  output logic                    frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0]          SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_ACTIVE_LOW}};

  typedef struct packed {
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   digit_en;
    logic [N_DIGITS-1:0]   blink_mask;
  } frame_t;

  frame_t            load_dat;
  frame_t            shadow_q;
  frame_t            disp_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  idx;
  logic [FR_W-1:0]   frame_cnt;
  logic              blink_phase;

  logic              slot_end;
  logic              frame_end;
  logic              blink_end;
  logic [N_DIGITS-1:0] lz_mask;
  logic              any_nz;
  logic [3:0]        sel_nib;
  logic              sel_blank;
  logic [6:0]        sel_seg;
  logic [N_DIGITS-1:0] an_sel;

  assign load_dat  = {data, dp, digit_en, blink_mask};
  assign slot_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(N_DIGITS - 1));
  assign blink_end = (frame_cnt == FR_W'(BLINK_FRAMES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      shadow_q    <= '0;
      disp_q      <= '0;
      frame_done  <= 1'b0;
    end else begin
      div_cnt    <= slot_end ? '0 : div_cnt + DIV_W'(1);
      frame_done <= frame_end;
      if (load) begin
        shadow_q <= load_dat;
      end
      if (slot_end) begin
        idx <= frame_end ? '0 : idx + IDX_W'(1);
      end
      // Display only moves at the frame wrap; a load in that same cycle lands one frame later.
      if (frame_end) begin
        disp_q <= shadow_q;
        if (blink_end) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FR_W'(1);
        end
      end
    end
  end

  // Suffix-OR from the most significant digit down: a digit is a leading zero
  // when it and every digit above it are zero. Digit 0 is always shown.
  always_comb begin
    any_nz  = 1'b0;
    lz_mask = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      any_nz     = any_nz | (|disp_q.data[4*i +: 4]);
      lz_mask[i] = lz_blank && (i > 0) && !any_nz;
    end
  end

  always_comb begin
    sel_nib   = disp_q.data[{idx, 2'b00} +: 4];
    sel_blank = !disp_q.digit_en[idx]
              || (disp_q.blink_mask[idx] && blink_phase)
              || lz_mask[idx];
    an_sel      = '0;
    an_sel[idx] = 1'b1;
  end

  seg_hex_decode u_dec (
    .nib   (sel_nib),
    .blank (sel_blank),
    .seg   (sel_seg)
  );

  // Anode and segments share one register stage so they always switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= SEG_OFF;
      dp_out  <= DP_OFF;
      an_out  <= AN_OFF;
    end else begin
      seg_out <= sel_seg ^ SEG_OFF;
      dp_out  <= (disp_q.dp[idx] && !sel_blank) ^ DP_OFF;
      an_out  <= an_sel ^ AN_OFF;
    end
  end

endmodule
